// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants, default reset vector and fetch-state encoding for the
// PC / fetch-address generator.
package pc_fetch_ctrl_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic Branch      = 1'b1;

  localparam logic [31:0] DefaultResetVec = 32'hBFC0_0000;

  typedef enum logic {
    RUN     = 1'b0,
    HOLD_BR = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_redirect_buf.sv
// One-entry pending-redirect buffer. Its valid flag is the fetch FSM state
// (RUN / HOLD_BR), so a redirect taken during a stall survives until release.
module pc_redirect_buf
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              clear_i,
  input  logic              consume_i,
  output logic [ADDR_W-1:0] pend_addr_o,
  output fetch_state_e      state_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= RUN;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Clear beats load; a newer load simply overwrites an older pending entry.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (clear_i) begin
      state_d = RUN;
    end else if (load_i) begin
      state_d = HOLD_BR;
      addr_d  = addr_i;
    end else if (consume_i) begin
      state_d = RUN;
    end
  end

  assign pend_addr_o = addr_q;
  assign state_o     = state_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-address generator with stall-safe branch buffering.
// Optional misaligned-fetch flag enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC    = ADDR_W'(DefaultResetVec),
  parameter int                STEP         = 4,
  parameter int                REDIRECT_OFS = 4,
  parameter int                STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               br_pending_o,
  output logic               fetch_exc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pendAddr;
  fetch_state_e      state;
  logic              fetchStop;
  logic              redirect;
  logic              bufLoad, bufClear, bufConsume;
  logic              unusedStall;

  assign fetchStop   = (stall[0] == Stop);
  assign unusedStall = ^stall[STALL_W-1:1];

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
    .clk        (clk),
    .rst        (rst),
    .load_i     (bufLoad),
    .addr_i     (branch_target_address_i),
    .clear_i    (bufClear),
    .consume_i  (bufConsume),
    .pend_addr_o(pendAddr),
    .state_o    (state)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) pc_q <= RESET_VEC;
    else                  pc_q <= pc_d;
  end

  // Flush overrides stall; any unstalled edge consumes the buffer, with a
  // live branch taking precedence over the buffered one.
  always_comb begin
    pc_d       = pc_q;
    redirect   = 1'b0;
    bufLoad    = 1'b0;
    bufClear   = 1'b0;
    bufConsume = 1'b0;
    if (flush) begin
      pc_d     = new_pc + ADDR_W'(REDIRECT_OFS);
      bufClear = 1'b1;
    end else if (fetchStop) begin
      bufLoad = (branch_flag_i == Branch);
    end else begin
      bufConsume = 1'b1;
      if (branch_flag_i == Branch) begin
        pc_d     = branch_target_address_i + ADDR_W'(REDIRECT_OFS);
        redirect = 1'b1;
      end else if (state == HOLD_BR) begin
        pc_d     = pendAddr + ADDR_W'(REDIRECT_OFS);
        redirect = 1'b1;
      end else begin
        pc_d = pc_q + ADDR_W'(STEP);
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic excQ, excD;
  logic misaligned;

  assign misaligned = |pc_d[1:0];

  // Redirects set or clear the flag; stepping can only clear it.
  always_comb begin
    excD = excQ;
    if (flush)           excD = 1'b0;
    else if (!fetchStop) excD = redirect ? misaligned : (excQ & misaligned);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) excQ <= 1'b0;
    else                  excQ <= excD;
  end

  assign fetch_exc_o = excQ;
`else
  logic unusedRedirect;
  assign unusedRedirect = redirect;
  assign fetch_exc_o    = 1'b0;
`endif

  assign pc           = pc_q;
  assign ce           = ((rst != RstEnable) && !fetchStop) ? ChipEnable : ChipDisable;
  assign br_pending_o = (state == HOLD_BR);

endmodule
